// File: rtl/mem_access_stage.sv
// MEM pipeline stage: one data-memory access per instruction over a req/ack bus,
// with store lane steering, load alignment, stall generation and the MEM/WB register.
//
// state  | meaning
// IDLE   | no access in flight; MEM/WB follows EX/MEM each cycle
// BUSY   | dmem_req held; waiting for dmem_ack or the timeout abort
module mem_access_stage #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_aluans,
   input  logic [31:0] in_stdata,
   input  logic        in_memread,
   input  logic        in_memwrite,
   input  logic [1:0]  in_size,
   input  logic        in_signlw,
   input  logic        in_memtoreg,
   input  logic        in_linksig,
   input  logic [31:0] in_linkpc,
   input  logic        in_regwrite,
   input  logic [4:0]  in_dst,
   output logic        mem_stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [31:0] wb_loadword,
   output logic [1:0]  wb_size,
   output logic        wb_signlw,
   output logic        wb_memtoreg,
   output logic        wb_linksig,
   output logic [31:0] wb_linkpc,
   output logic [31:0] wb_aluans,
   output logic [4:0]  wb_dst,
   output logic        wb_regwrite,
   output logic        wb_excp
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_q, req_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       be_q, be_d;
   logic [1:0]       lo_q, lo_d;

   logic             wb_valid_q, wb_valid_d;
   logic [31:0]      wb_loadword_q, wb_loadword_d;
   logic [1:0]       wb_size_q, wb_size_d;
   logic             wb_signlw_q, wb_signlw_d;
   logic             wb_memtoreg_q, wb_memtoreg_d;
   logic             wb_linksig_q, wb_linksig_d;
   logic [31:0]      wb_linkpc_q, wb_linkpc_d;
   logic [31:0]      wb_aluans_q, wb_aluans_d;
   logic [4:0]       wb_dst_q, wb_dst_d;
   logic             wb_regwrite_q, wb_regwrite_d;
   logic             wb_excp_q, wb_excp_d;

   logic        is_mem, misalign, start, ack_hit, tmo_hit;
   logic [31:0] st_wdata, ld_align, ld_shift;
   logic [3:0]  st_be;

   assign is_mem  = in_valid && (in_memread || in_memwrite);
   assign start   = (state_q == S_IDLE) && is_mem && !misalign;
   assign ack_hit = (state_q == S_BUSY) && dmem_ack;
   assign tmo_hit = (state_q == S_BUSY) && !dmem_ack && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      misalign = 1'b0;
      st_wdata = in_stdata;
      st_be    = 4'b1111;
      case (in_size)
         2'b01: begin
            misalign = in_aluans[0];
            st_wdata = {2{in_stdata[15:0]}};
            st_be    = in_aluans[1] ? 4'b1100 : 4'b0011;
         end
         2'b10: begin
            st_wdata = {4{in_stdata[7:0]}};
            st_be    = 4'b0001 << in_aluans[1:0];
         end
         default: misalign = (in_aluans[1:0] != 2'b00);
      endcase
   end

   // Alignment uses the offset captured at issue, not the live address.
   always_comb begin
      ld_shift = dmem_rdata >> {lo_q, 3'b000};
      case (in_size)
         2'b01:   ld_align = lo_q[1] ? {16'h0, dmem_rdata[31:16]} : {16'h0, dmem_rdata[15:0]};
         2'b10:   ld_align = {24'h0, ld_shift[7:0]};
         default: ld_align = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         req_q         <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         be_q          <= '0;
         lo_q          <= '0;
         wb_valid_q    <= 1'b0;
         wb_loadword_q <= '0;
         wb_size_q     <= '0;
         wb_signlw_q   <= 1'b0;
         wb_memtoreg_q <= 1'b0;
         wb_linksig_q  <= 1'b0;
         wb_linkpc_q   <= '0;
         wb_aluans_q   <= '0;
         wb_dst_q      <= '0;
         wb_regwrite_q <= 1'b0;
         wb_excp_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         req_q         <= req_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         be_q          <= be_d;
         lo_q          <= lo_d;
         wb_valid_q    <= wb_valid_d;
         wb_loadword_q <= wb_loadword_d;
         wb_size_q     <= wb_size_d;
         wb_signlw_q   <= wb_signlw_d;
         wb_memtoreg_q <= wb_memtoreg_d;
         wb_linksig_q  <= wb_linksig_d;
         wb_linkpc_q   <= wb_linkpc_d;
         wb_aluans_q   <= wb_aluans_d;
         wb_dst_q      <= wb_dst_d;
         wb_regwrite_q <= wb_regwrite_d;
         wb_excp_q     <= wb_excp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_BUSY;
         S_BUSY:  if (ack_hit || tmo_hit) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d         = '0;
      req_d         = req_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      be_d          = be_q;
      lo_d          = lo_q;
      mem_stall     = 1'b0;
      wb_valid_d    = wb_valid_q;
      wb_loadword_d = wb_loadword_q;
      wb_size_d     = wb_size_q;
      wb_signlw_d   = wb_signlw_q;
      wb_memtoreg_d = wb_memtoreg_q;
      wb_linksig_d  = wb_linksig_q;
      wb_linkpc_d   = wb_linkpc_q;
      wb_aluans_d   = wb_aluans_q;
      wb_dst_d      = wb_dst_q;
      wb_regwrite_d = wb_regwrite_q;
      wb_excp_d     = wb_excp_q;

      // Upstream holds in_* stable while stalled, so completion copies them directly.
      if (!start && !(state_q == S_BUSY && !ack_hit && !tmo_hit)) begin
         wb_size_d     = in_size;
         wb_signlw_d   = in_signlw;
         wb_memtoreg_d = in_memtoreg;
         wb_linksig_d  = in_linksig;
         wb_linkpc_d   = in_linkpc;
         wb_aluans_d   = in_aluans;
         wb_dst_d      = in_dst;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mem_stall     = 1'b1;
               req_d         = 1'b1;
               we_d          = in_memwrite;
               addr_d        = {in_aluans[31:2], 2'b00};
               wdata_d       = st_wdata;
               be_d          = st_be;
               lo_d          = in_aluans[1:0];
               wb_valid_d    = 1'b0;
               wb_excp_d     = 1'b0;
               wb_regwrite_d = 1'b0;
            end else begin
               wb_valid_d    = in_valid;
               wb_excp_d     = is_mem && misalign;
               wb_regwrite_d = in_regwrite && !(is_mem && misalign);
               wb_loadword_d = '0;
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (ack_hit) begin
               req_d         = 1'b0;
               wb_valid_d    = 1'b1;
               wb_excp_d     = 1'b0;
               wb_regwrite_d = in_regwrite;
               wb_loadword_d = in_memread ? ld_align : 32'h0;
            end else if (tmo_hit) begin
               req_d         = 1'b0;
               wb_valid_d    = 1'b1;
               wb_excp_d     = 1'b1;
               wb_regwrite_d = 1'b0;
               wb_loadword_d = '0;
            end else begin
               mem_stall = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign dmem_req    = req_q;
   assign dmem_we     = we_q;
   assign dmem_addr   = addr_q;
   assign dmem_wdata  = wdata_q;
   assign dmem_be     = be_q;
   assign wb_valid    = wb_valid_q;
   assign wb_loadword = wb_loadword_q;
   assign wb_size     = wb_size_q;
   assign wb_signlw   = wb_signlw_q;
   assign wb_memtoreg = wb_memtoreg_q;
   assign wb_linksig  = wb_linksig_q;
   assign wb_linkpc   = wb_linkpc_q;
   assign wb_aluans   = wb_aluans_q;
   assign wb_dst      = wb_dst_q;
   assign wb_regwrite = wb_regwrite_q;
   assign wb_excp     = wb_excp_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus randomized instructions against a
// transaction-level model of lanes, alignment, stall length and exceptions.
module tb_mem_access_stage;
   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_memread, in_memwrite, in_signlw, in_memtoreg, in_linksig, in_regwrite;
   logic [31:0] in_aluans, in_stdata, in_linkpc;
   logic [1:0]  in_size;
   logic [4:0]  in_dst;
   logic        mem_stall, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        wb_valid, wb_signlw, wb_memtoreg, wb_linksig, wb_regwrite, wb_excp;
   logic [31:0] wb_loadword, wb_linkpc, wb_aluans;
   logic [1:0]  wb_size;
   logic [4:0]  wb_dst;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT_CYC(T)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_aluans(in_aluans), .in_stdata(in_stdata),
      .in_memread(in_memread), .in_memwrite(in_memwrite), .in_size(in_size), .in_signlw(in_signlw),
      .in_memtoreg(in_memtoreg), .in_linksig(in_linksig), .in_linkpc(in_linkpc),
      .in_regwrite(in_regwrite), .in_dst(in_dst), .mem_stall(mem_stall), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_loadword(wb_loadword),
      .wb_size(wb_size), .wb_signlw(wb_signlw), .wb_memtoreg(wb_memtoreg), .wb_linksig(wb_linksig),
      .wb_linkpc(wb_linkpc), .wb_aluans(wb_aluans), .wb_dst(wb_dst), .wb_regwrite(wb_regwrite),
      .wb_excp(wb_excp)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d, input logic lk,
                         input logic [31:0] lpc, input logic rw, input logic [4:0] dst);
      in_valid = v;  in_memread = rd;  in_memwrite = wr;  in_size = sz;
      in_aluans = a; in_stdata = d;    in_linksig = lk;   in_linkpc = lpc;
      in_regwrite = rw; in_dst = dst;  in_memtoreg = rd;  in_signlw = 1'($urandom);
   endtask

   // Caller is at a negedge with in_* applied; returns at the negedge after MEM/WB updates.
   task automatic run_txn(input int ack_at, input logic [31:0] rd, input bit stray);
      logic [1:0]  a;
      logic        is_mem, mis, acked, done, excp;
      logic [31:0] exp_wdata, exp_ld;
      logic [3:0]  exp_be;
      int          req_cnt;
      a      = in_aluans[1:0];
      is_mem = in_valid && (in_memread || in_memwrite);
      if (in_size == 2'b01)      mis = a[0];
      else if (in_size == 2'b10) mis = 1'b0;
      else                       mis = (a != 2'b00);
      mis = mis && is_mem;
      if (in_size == 2'b10) begin
         exp_wdata = (in_stdata & 32'hFF) * 32'h01010101;
         exp_be    = 4'(1 << a);
         exp_ld    = (rd >> (8 * a)) & 32'hFF;
      end else if (in_size == 2'b01) begin
         exp_wdata = (in_stdata & 32'hFFFF) * 32'h00010001;
         exp_be    = a[1] ? 4'hC : 4'h3;
         exp_ld    = (rd >> (16 * a[1])) & 32'hFFFF;
      end else begin
         exp_wdata = in_stdata;
         exp_be    = 4'hF;
         exp_ld    = rd;
      end
      dmem_ack   = stray;
      dmem_rdata = $urandom;
      #1 chk("stall_issue", 32'(mem_stall), 32'(is_mem && !mis));
      acked   = 1'b0;
      req_cnt = 0;
      done    = !(is_mem && !mis);
      for (int c = 0; c < T + 3 && !done; c++) begin
         @(negedge clk);
         dmem_ack = 1'b0;
         if (!dmem_req) begin
            chk("req_held", 32'(dmem_req), 32'd1);
            break;
         end
         req_cnt++;
         if (c == 0) begin
            chk("bus_addr", dmem_addr, {in_aluans[31:2], 2'b00});
            chk("bus_we", 32'(dmem_we), 32'(in_memwrite));
            chk("bus_be", 32'(dmem_be), 32'(exp_be));
            if (in_memwrite) chk("bus_wdata", dmem_wdata, exp_wdata);
            chk("wb_valid_busy", 32'(wb_valid), 32'd0);
         end
         if (c == ack_at) begin
            dmem_ack   = 1'b1;
            dmem_rdata = rd;
            acked      = 1'b1;
            done       = 1'b1;
            #1 chk("stall_ack", 32'(mem_stall), 32'd0);
         end else if (c == T - 1) begin
            done = 1'b1;
         end else begin
            #1 chk("stall_busy", 32'(mem_stall), 32'd1);
         end
      end
      chk("txn_done", 32'(done), 32'd1);
      if (is_mem && !mis)
         chk("req_cycles", req_cnt, (ack_at < T) ? ack_at + 1 : T);
      @(negedge clk);
      dmem_ack = 1'b0;
      excp = mis || (is_mem && !mis && !acked);
      chk("req_after", 32'(dmem_req), 32'd0);
      chk("wb_flags", {24'h0, wb_valid, wb_excp, wb_regwrite, wb_linksig, wb_memtoreg, wb_signlw, wb_size},
          {24'h0, in_valid, excp, in_regwrite && !excp, in_linksig, in_memtoreg, in_signlw, in_size});
      chk("wb_loadword", wb_loadword, (in_memread && acked) ? exp_ld : 32'h0);
      chk("wb_aluans", wb_aluans, in_aluans);
      chk("wb_linkpc", wb_linkpc, in_linkpc);
      chk("wb_dst", 32'(wb_dst), 32'(in_dst));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_bus"}, {26'h0, dmem_req, dmem_we, dmem_be}, 32'h0);
      chk({tag, "_flags"}, {24'h0, wb_valid, wb_excp, wb_regwrite, wb_linksig, wb_memtoreg, wb_signlw, wb_size}, 32'h0);
      chk({tag, "_ld"}, wb_loadword, 32'h0);
      chk({tag, "_alu"}, wb_aluans, 32'h0);
      chk({tag, "_lpc"}, wb_linkpc, 32'h0);
      chk({tag, "_dst"}, 32'(wb_dst), 32'h0);
      chk({tag, "_stall"}, 32'(mem_stall), 32'h0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      dmem_ack = 1'b0;
      dmem_rdata = '0;
      set_in(0, 0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 5'd0);
      repeat (3) @(negedge clk);
      chk_reset_state("reset");
      rst = 1'b0;

      set_in(1, 1, 0, 2'b10, 32'h1003, 32'h0, 0, 32'h0, 1, 5'd3);
      run_txn(0, 32'hAABBCCDD, 1'b0);
      set_in(1, 0, 1, 2'b01, 32'h2002, 32'h00001234, 0, 32'h0, 0, 5'd0);
      run_txn(2, 32'h0, 1'b0);
      set_in(1, 1, 0, 2'b00, 32'h3001, 32'h0, 0, 32'h0, 1, 5'd7);
      run_txn(0, 32'h0, 1'b0);
      set_in(1, 1, 0, 2'b00, 32'h4000, 32'h0, 0, 32'h0, 1, 5'd9);
      run_txn(T + 1, 32'h0, 1'b0);
      set_in(1, 0, 0, 2'b00, 32'h11223344, 32'h0, 0, 32'h0, 1, 5'd4);
      run_txn(0, 32'h0, 1'b1);
      set_in(1, 0, 0, 2'b00, 32'h00000008, 32'h0, 1, 32'h0040_0010, 1, 5'd31);
      run_txn(0, 32'h0, 1'b0);

      set_in(1, 1, 0, 2'b00, 32'h5000, 32'h0, 0, 32'h0, 1, 5'd5);
      dmem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy_req", 32'(dmem_req), 32'd1);
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk_reset_state("rst_busy");
      rst = 1'b0;

      for (int i = 0; i < 300; i++) begin
         int kind;
         kind = int'($urandom_range(0, 3));
         set_in(kind != 3, kind == 1, kind == 2, 2'($urandom), $urandom, $urandom,
                1'($urandom), $urandom, 1'($urandom), 5'($urandom));
         run_txn(int'($urandom_range(0, T + 1)), $urandom, 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
